// File: rtl/des_pkg.sv
// Shared DES definitions: block/half/subkey typedefs, controller state
// encoding, the standard permutation and S-box tables, and helpers for
// applying them. Bit 0 of every vector is DES bit 1 (the MSB).
package des_pkg;

  typedef logic [0:63] des_block_t;
  typedef logic [0:31] des_half_t;
  typedef logic [0:47] des_subkey_t;
  typedef logic [0:27] des_cd_t;
  typedef logic [0:55] des_cd_pair_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } des_state_t;

  // Encrypt rotate amounts per round; decrypt walks this table backwards.
  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Indexed by {row(b1,b6), column(b2..b5)}, i.e. row*16 + column.
  localparam int SBOX_TBL [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  function automatic des_block_t des_ip(input des_block_t x);
    des_block_t y;
    for (int i = 0; i < 64; i++) y[i] = x[IP_TBL[i] - 1];
    return y;
  endfunction

  function automatic des_block_t des_fp(input des_block_t x);
    des_block_t y;
    for (int i = 0; i < 64; i++) y[i] = x[FP_TBL[i] - 1];
    return y;
  endfunction

  // Parity bits never appear in PC1_TBL, so they drop out here.
  function automatic des_cd_pair_t des_pc1(input des_block_t x);
    des_cd_pair_t y;
    for (int i = 0; i < 56; i++) y[i] = x[PC1_TBL[i] - 1];
    return y;
  endfunction

  function automatic des_subkey_t des_pc2(input des_cd_pair_t x);
    des_subkey_t y;
    for (int i = 0; i < 48; i++) y[i] = x[PC2_TBL[i] - 1];
    return y;
  endfunction

  function automatic des_subkey_t des_e(input des_half_t x);
    des_subkey_t y;
    for (int i = 0; i < 48; i++) y[i] = x[E_TBL[i] - 1];
    return y;
  endfunction

  function automatic des_half_t des_p(input des_half_t x);
    des_half_t y;
    for (int i = 0; i < 32; i++) y[i] = x[P_TBL[i] - 1];
    return y;
  endfunction

  function automatic des_half_t des_sbox(input des_subkey_t x);
    des_half_t  y;
    logic [5:0] six;
    for (int i = 0; i < 8; i++) begin
      six = x[6*i +: 6];
      y[4*i +: 4] = 4'(SBOX_TBL[i][{six[5], six[0], six[4:1]}]);
    end
    return y;
  endfunction

  function automatic des_cd_t des_rotl(input des_cd_t x, input logic [1:0] n);
    des_cd_t y;
    case (n)
      2'd1:    y = {x[1:27], x[0]};
      2'd2:    y = {x[2:27], x[0:1]};
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic des_cd_t des_rotr(input des_cd_t x, input logic [1:0] n);
    des_cd_t y;
    case (n)
      2'd1:    y = {x[27], x[0:26]};
      2'd2:    y = {x[26:27], x[0:25]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_feistel_round.sv
// One combinational DES round: R' = L ^ P(S(E(R) ^ K)).
module des_feistel_round
  import des_pkg::*;
(
  input  des_half_t   l,
  input  des_half_t   r,
  input  des_subkey_t subkey,
  output des_half_t   r_next
);

  des_subkey_t e_mix;
  des_half_t   s_out;

  // Expansion, key mix, substitution, permutation, then fold into L.
  always_comb begin
    e_mix  = des_e(r) ^ subkey;
    s_out  = des_sbox(e_mix);
    r_next = l ^ des_p(s_out);
  end

endmodule

// File: rtl/des_iter_ctrl.sv
// Iterative DES controller: one Feistel round per clock with on-the-fly
// subkey generation, IP on accept and swap+FP folded into the last round.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | in_ready high, waiting for a job
//   RUN   | one round per cycle, rnd_q = 0 .. NUM_ROUNDS-1
//   DONE  | out_valid high, text_out held until out_ready
module des_iter_ctrl
  import des_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] text_in,
  input  logic [0:63] key_in,
  input  logic        decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] text_out,
  output logic        busy
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  des_state_t   state_q, state_d;
  des_half_t    l_q, r_q, f_out;
  des_cd_t      c_q, d_q, c_nxt, d_nxt;
  logic [3:0]   rnd_q;
  logic         mode_q;
  des_block_t   text_out_q, ip_blk, fp_blk;
  des_cd_pair_t pc1_key;
  des_subkey_t  subkey;
  logic [1:0]   shift_amt;
  logic         accept, last_rnd;

  // Key schedule: decrypt replays the encrypt rotations in reverse order,
  // with no rotation before its first round.
  always_comb begin
    shift_amt = 2'd0;
    if (!mode_q) begin
      shift_amt = SHIFT_SCHED[rnd_q];
    end else if (rnd_q != 4'd0) begin
      shift_amt = SHIFT_SCHED[4'd0 - rnd_q];
    end
    c_nxt   = mode_q ? des_rotr(c_q, shift_amt) : des_rotl(c_q, shift_amt);
    d_nxt   = mode_q ? des_rotr(d_q, shift_amt) : des_rotl(d_q, shift_amt);
    subkey  = des_pc2({c_nxt, d_nxt});
    ip_blk  = des_ip(text_in);
    pc1_key = des_pc1(key_in);
    // Final swap: R_next goes to the left half, L_next (= R) to the right.
    fp_blk  = des_fp({f_out, r_q});
  end

  des_feistel_round u_round (
    .l      (l_q),
    .r      (r_q),
    .subkey (subkey),
    .r_next (f_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    last_rnd  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (rnd_q == LAST_RND) begin
          last_rnd = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate while running, capture result on last round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      rnd_q      <= '0;
      mode_q     <= 1'b0;
      text_out_q <= '0;
    end else if (accept) begin
      l_q    <= ip_blk[0:31];
      r_q    <= ip_blk[32:63];
      c_q    <= pc1_key[0:27];
      d_q    <= pc1_key[28:55];
      mode_q <= decrypt;
      rnd_q  <= '0;
    end else if (state_q == RUN) begin
      l_q <= r_q;
      r_q <= f_out;
      c_q <= c_nxt;
      d_q <= d_nxt;
      if (last_rnd) text_out_q <= fp_blk;
      else          rnd_q      <= rnd_q + 4'd1;
    end
  end

  assign text_out = text_out_q;

endmodule
